// File: rtl/game_state_controller.sv
// Game sequencer: debounces start/pause, runs IDLE/PLAYING/PAUSED/OVER,
// and keeps the BCD score plus the session high score for the HUD.
module game_state_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [15:0] SCORE_MAX       = 16'h9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        alien_hit,
    input  logic        game_over,
    output logic        pause,
    output logic        game_reset,
    output logic [1:0]  state,
    output logic [15:0] score_bcd,
    output logic [15:0] high_score_bcd
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    // Index 0 is the start button, index 1 the pause button.
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, deb_dly_q, deb_dly_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic               hit_dly_q, hit_dly_d, over_dly_q, over_dly_d;
    state_t             state_q, state_d;
    logic               pause_q, pause_d, game_reset_q, game_reset_d;
    logic [15:0]        score_q, score_d, high_q, high_d;
    logic [1:0]         press;
    logic               hit_ev, over_ev;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        sync1_d   = {btn_pause, btn_start};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        cnt_d     = cnt_q;
        deb_dly_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES)) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        press      = deb_q & ~deb_dly_q;
        hit_dly_d  = alien_hit;
        over_dly_d = game_over;
        // Status inputs are levels; only their rising edges act.
        hit_ev     = alien_hit & ~hit_dly_q;
        over_ev    = game_over & ~over_dly_q;
    end

    always_comb begin
        state_d      = state_q;
        game_reset_d = 1'b0;
        score_d      = score_q;
        high_d       = high_q;
        case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    state_d      = S_PLAY;
                    game_reset_d = 1'b1;
                    score_d      = '0;
                end
            end
            S_PLAY: begin
                if (hit_ev && score_q < SCORE_MAX) score_d = bcd_inc(score_q);
                if (over_ev)       state_d = S_OVER;
                else if (press[1]) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (press[0] || press[1]) state_d = S_PLAY;
            end
            S_OVER: begin
                // Packed BCD orders the same as plain unsigned binary.
                if (score_q > high_q) high_d = score_q;
                if (press[0]) begin
                    state_d      = S_PLAY;
                    game_reset_d = 1'b1;
                    score_d      = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pause_d = (state_d != S_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            deb_dly_q    <= '0;
            cnt_q        <= '0;
            hit_dly_q    <= 1'b0;
            over_dly_q   <= 1'b0;
            state_q      <= S_IDLE;
            pause_q      <= 1'b1;
            game_reset_q <= 1'b0;
            score_q      <= '0;
            high_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_q        <= deb_d;
            deb_dly_q    <= deb_dly_d;
            cnt_q        <= cnt_d;
            hit_dly_q    <= hit_dly_d;
            over_dly_q   <= over_dly_d;
            state_q      <= state_d;
            pause_q      <= pause_d;
            game_reset_q <= game_reset_d;
            score_q      <= score_d;
            high_q       <= high_d;
        end
    end

    assign state          = state_q;
    assign pause          = pause_q;
    assign game_reset     = game_reset_q;
    assign score_bcd      = score_q;
    assign high_score_bcd = high_q;
endmodule

// File: tb/tb_game_state_controller.sv
// Bench for game_state_controller: directed scenarios plus random traffic,
// all checked every cycle against a sample-history reference model.
module tb_game_state_controller;
    localparam int D = 4;
    localparam logic [1:0] M_IDLE = 2'b00, M_PLAY = 2'b01, M_PAUSE = 2'b10, M_OVER = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_start = 1'b0, btn_pause = 1'b0, alien_hit = 1'b0, game_over = 1'b0;
    logic        pause, game_reset;
    logic [1:0]  state;
    logic [15:0] score_bcd, high_score_bcd;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: score kept as a plain decimal integer; a button's
    // accepted level flips once the D+1 raw samples preceding the two
    // synchronizer stages all disagree with it.
    logic [1:0] m_state;
    int         m_score, m_high;
    bit         m_gr, m_a_prev, m_g_prev;
    bit         m_deb [2];
    bit         m_press [2];
    bit         hist [2][D+3];

    game_state_controller #(.DEBOUNCE_CYCLES(D), .SCORE_MAX(16'h9999)) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
        .alien_hit(alien_hit), .game_over(game_over), .pause(pause),
        .game_reset(game_reset), .state(state), .score_bcd(score_bcd),
        .high_score_bcd(high_score_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_edge();
        bit hit, over, sp, pp, all_dis, raw;
        if (reset) begin
            m_state = M_IDLE; m_score = 0; m_high = 0; m_gr = 0;
            m_a_prev = 0; m_g_prev = 0;
            for (int b = 0; b < 2; b++) begin
                m_deb[b] = 0; m_press[b] = 0;
                for (int j = 0; j < D+3; j++) hist[b][j] = 0;
            end
        end else begin
            hit  = alien_hit && !m_a_prev;
            over = game_over && !m_g_prev;
            sp   = m_press[0];
            pp   = m_press[1];
            m_gr = 0;
            if (m_state == M_IDLE) begin
                if (sp) begin m_state = M_PLAY; m_gr = 1; m_score = 0; end
            end else if (m_state == M_PLAY) begin
                if (hit && m_score < 9999) m_score++;
                if (over) m_state = M_OVER;
                else if (pp) m_state = M_PAUSE;
            end else if (m_state == M_PAUSE) begin
                if (sp || pp) m_state = M_PLAY;
            end else begin
                if (m_score > m_high) m_high = m_score;
                if (sp) begin m_state = M_PLAY; m_gr = 1; m_score = 0; end
            end
            m_a_prev = alien_hit;
            m_g_prev = game_over;
            for (int b = 0; b < 2; b++) begin
                raw = (b == 0) ? btn_start : btn_pause;
                for (int j = 0; j < D+2; j++) hist[b][j] = hist[b][j+1];
                hist[b][D+2] = raw;
                all_dis = 1;
                for (int j = 0; j <= D; j++) if (hist[b][j] == m_deb[b]) all_dis = 0;
                m_press[b] = 0;
                if (all_dis) begin
                    m_deb[b]   = !m_deb[b];
                    m_press[b] = m_deb[b];
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", {14'd0, state}, {14'd0, m_state});
        chk("pause", {15'd0, pause}, {15'd0, (m_state != M_PLAY)});
        chk("game_reset", {15'd0, game_reset}, {15'd0, m_gr});
        chk("score", score_bcd, to_bcd(m_score));
        chk("high", high_score_bcd, to_bcd(m_high));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input bit which);
        if (which) btn_pause = 1'b1; else btn_start = 1'b1;
        ticks(2*D);
        btn_start = 1'b0; btn_pause = 1'b0;
        ticks(2*D);
    endtask

    task automatic hits(input int n);
        repeat (n) begin
            alien_hit = 1'b1; tick();
            alien_hit = 1'b0; tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        int edges;
        // Reset and start latency
        ticks(2);
        chk("rst_state", {14'd0, state}, 16'h0000);
        chk("rst_pause", {15'd0, pause}, 16'h0001);
        chk("rst_score", score_bcd, 16'h0000);
        chk("rst_high", high_score_bcd, 16'h0000);
        reset = 1'b0;
        btn_start = 1'b1;
        edges = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (state == M_PLAY) begin edges = i; break; end
        end
        chk("start_edges", 16'(edges), 16'd8);
        chk("start_greset", {15'd0, game_reset}, 16'h0001);
        chk("start_pause", {15'd0, pause}, 16'h0000);
        ticks(12);
        btn_start = 1'b0; ticks(10);

        // Bounce rejection
        repeat (4) begin
            btn_pause = 1'b1; ticks(3);
            btn_pause = 1'b0; ticks(1);
        end
        btn_pause = 1'b1; ticks(10);
        btn_pause = 1'b0; ticks(10);
        chk("bounce_state", {14'd0, state}, 16'h0002);
        chk("bounce_pause", {15'd0, pause}, 16'h0001);
        press(1'b1);
        chk("resume_state", {14'd0, state}, 16'h0001);

        // Scoring with wide pulses, then BCD carry
        repeat (12) begin
            alien_hit = 1'b1; ticks(3);
            alien_hit = 1'b0; ticks(1);
        end
        chk("score12", score_bcd, 16'h0012);
        hits(87);
        chk("score99", score_bcd, 16'h0099);
        hits(1);
        chk("score100", score_bcd, 16'h0100);

        // Pause freeze
        press(1'b1);
        alien_hit = 1'b1; ticks(2); alien_hit = 1'b0;
        game_over = 1'b1; ticks(2); game_over = 1'b0; ticks(2);
        chk("frz_score", score_bcd, 16'h0100);
        chk("frz_state", {14'd0, state}, 16'h0002);
        press(1'b1);

        // Game over and high score retention
        do_reset();
        press(1'b0);
        hits(42);
        game_over = 1'b1; tick();
        chk("over_state", {14'd0, state}, 16'h0003);
        tick();
        chk("over_high", high_score_bcd, 16'h0042);
        press(1'b0);
        chk("restart_state", {14'd0, state}, 16'h0001);
        chk("restart_score", score_bcd, 16'h0000);
        hits(17);
        game_over = 1'b0; tick();
        game_over = 1'b1; ticks(2);
        chk("over2_state", {14'd0, state}, 16'h0003);
        chk("over2_high", high_score_bcd, 16'h0042);
        game_over = 1'b0;

        // Simultaneous hit and game over, then reset in OVER
        do_reset();
        press(1'b0);
        hits(5);
        alien_hit = 1'b1; game_over = 1'b1; tick();
        chk("sim_score", score_bcd, 16'h0006);
        chk("sim_state", {14'd0, state}, 16'h0003);
        tick();
        chk("sim_high", high_score_bcd, 16'h0006);
        alien_hit = 1'b0; game_over = 1'b0;
        reset = 1'b1; tick();
        chk("rst2_state", {14'd0, state}, 16'h0000);
        chk("rst2_high", high_score_bcd, 16'h0000);
        reset = 1'b0;

        // Saturation
        press(1'b0);
        hits(9999);
        chk("sat_score", score_bcd, 16'h9999);
        hits(1);
        chk("sat_hold", score_bcd, 16'h9999);

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)   btn_start = ~btn_start;
            if ($urandom_range(0, 11) == 0)  btn_pause = ~btn_pause;
            if ($urandom_range(0, 2) == 0)   alien_hit = ~alien_hit;
            if ($urandom_range(0, 19) == 0)  game_over = ~game_over;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
